// File: rtl/instruction_fetch_stage.sv
// IF stage of the RV64I pipeline: PC sequencing, word-addressed instruction memory
// and the IF/ID register presented to decode.
module instruction_fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] NOP_INSN   = 32'h00000013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [63:0] branch_target_i,
  input  logic        imem_we_i,
  input  logic [63:0] imem_waddr_i,
  input  logic [31:0] imem_wdata_i,
  output logic [63:0] pc_o,
  output logic [63:0] if_id_pc_o,
  output logic [31:0] if_id_instruction_o,
  output logic        if_id_valid_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [4:0]  rd_addr_o,
  output logic        misaligned_o
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] mem_q [IMEM_DEPTH];

  logic [63:0] pc_q, pc_d;
  logic [63:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_insn_q, if_id_insn_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        misaligned_q, misaligned_d;

  logic        fetch_in_range;
  logic [31:0] fetch_word;
  logic        wr_in_range;
  logic        unused_waddr_lsb;

  assign unused_waddr_lsb = ^imem_waddr_i[1:0];

  // Anything outside the array or not word aligned fetches a bubble.
  assign fetch_in_range = (pc_q[63:AW+2] == '0) && (pc_q[1:0] == 2'b00);
  assign fetch_word     = fetch_in_range ? mem_q[pc_q[AW+1:2]] : NOP_INSN;
  assign wr_in_range    = (imem_waddr_i[63:AW+2] == '0);

  // Memory is not reset; writes land on the edge so a same-cycle fetch sees the old word.
  always_ff @(posedge clk_i) begin
    if (imem_we_i && wr_in_range) begin
      mem_q[imem_waddr_i[AW+1:2]] <= imem_wdata_i;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_insn_d  = if_id_insn_q;
    if_id_valid_d = if_id_valid_q;
    misaligned_d  = misaligned_q;
    if (flush_i) begin
      pc_d          = {branch_target_i[63:2], 2'b00};
      if_id_pc_d    = 64'h0;
      if_id_insn_d  = NOP_INSN;
      if_id_valid_d = 1'b0;
      misaligned_d  = misaligned_q | (branch_target_i[1:0] != 2'b00);
    end else if (!stall_i) begin
      pc_d          = pc_q + 64'd4;
      if_id_pc_d    = pc_q;
      if_id_insn_d  = fetch_word;
      if_id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 64'h0;
      if_id_insn_q  <= NOP_INSN;
      if_id_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_insn_q  <= if_id_insn_d;
      if_id_valid_q <= if_id_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign pc_o                = pc_q;
  assign if_id_pc_o          = if_id_pc_q;
  assign if_id_instruction_o = if_id_insn_q;
  assign if_id_valid_o       = if_id_valid_q;
  assign rs1_addr_o          = if_id_insn_q[19:15];
  assign rs2_addr_o          = if_id_insn_q[24:20];
  assign rd_addr_o           = if_id_insn_q[11:7];
  assign misaligned_o        = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: cycle model compared every cycle plus
// hand-computed checkpoints along a directed fetch/stall/flush/write sequence.
module tb_instruction_fetch_stage;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, stall, flush, imem_we;
  logic [63:0] branch_target, imem_waddr;
  logic [31:0] imem_wdata;
  logic [63:0] pc, if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid, misaligned;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch_stage #(.RESET_PC(64'h0), .IMEM_DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .branch_target_i(branch_target), .imem_we_i(imem_we), .imem_waddr_i(imem_waddr),
    .imem_wdata_i(imem_wdata), .pc_o(pc), .if_id_pc_o(if_id_pc),
    .if_id_instruction_o(if_id_instruction), .if_id_valid_o(if_id_valid),
    .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr), .rd_addr_o(rd_addr),
    .misaligned_o(misaligned)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch stage described as plain arithmetic on a word array.
  logic [31:0] m_mem [DEPTH];
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_insn;
  logic        m_valid, m_mis;

  always @(posedge clk) begin
    logic [31:0] fetched;
    if (m_pc < 64'(DEPTH * 4) && m_pc % 4 == 0) fetched = m_mem[int'(m_pc / 4)];
    else fetched = NOP;
    if (rst) begin
      m_pc = 64'h0; m_ifpc = 64'h0; m_insn = NOP; m_valid = 1'b0; m_mis = 1'b0;
    end else if (flush) begin
      m_pc = branch_target - (branch_target % 4);
      m_ifpc = 64'h0; m_insn = NOP; m_valid = 1'b0;
      if (branch_target % 4 != 0) m_mis = 1'b1;
    end else if (!stall) begin
      m_ifpc = m_pc; m_insn = fetched; m_valid = 1'b1;
      m_pc = m_pc + 64'd4;
    end
    if (imem_we && imem_waddr < 64'(DEPTH * 4)) m_mem[int'(imem_waddr / 4)] = imem_wdata;
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("pc", pc, m_pc);
      check("if_id_pc", if_id_pc, m_ifpc);
      check("insn", 64'(if_id_instruction), 64'(m_insn));
      check("valid", 64'(if_id_valid), 64'(m_valid));
      check("rs1", 64'(rs1_addr), 64'(m_insn[19:15]));
      check("rs2", 64'(rs2_addr), 64'(m_insn[24:20]));
      check("rd", 64'(rd_addr), 64'(m_insn[11:7]));
      check("misaligned", 64'(misaligned), 64'(m_mis));
    end
  end

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:  return 32'h00500093;
      1:  return 32'h00A00113;
      2:  return 32'h002081B3;
      3:  return 32'h00000013;
      16: return 32'h00C28293;
      20: return 32'h00100513;
      default: return 32'hA0000000 | 32'(i);
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic redirect(input logic [63:0] target);
    flush = 1'b1; branch_target = target;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = 64'h0;
    imem_we = 1'b0; imem_waddr = 64'h0; imem_wdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      imem_we = 1'b1; imem_waddr = 64'(i * 4); imem_wdata = init_word(i);
      tick();
      check_en = 1'b1;
    end
    imem_we = 1'b0;
    check("rst_valid", 64'(if_id_valid), 64'h0);
    check("rst_insn", 64'(if_id_instruction), 64'h13);
    check("rst_pc", pc, 64'h0);

    rst = 1'b0;
    tick();
    check("seq0_insn", 64'(if_id_instruction), 64'h00500093);
    check("seq0_ifpc", if_id_pc, 64'h0);
    check("seq0_pc", pc, 64'h4);
    check("seq0_valid", 64'(if_id_valid), 64'h1);
    tick();
    check("seq1_insn", 64'(if_id_instruction), 64'h00A00113);
    check("seq1_pc", pc, 64'h8);

    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_insn", 64'(if_id_instruction), 64'h00A00113);
      check("stall_pc", pc, 64'h8);
    end
    stall = 1'b0;
    tick();
    check("seq2_insn", 64'(if_id_instruction), 64'h002081B3);
    check("seq2_ifpc", if_id_pc, 64'h8);
    check("seq2_pc", pc, 64'hC);
    check("seq2_regs", 64'({rs1_addr, rs2_addr, rd_addr}), 64'({5'd1, 5'd2, 5'd3}));

    stall = 1'b1;
    redirect(64'h40);
    stall = 1'b0;
    check("flush_pc", pc, 64'h40);
    check("flush_valid", 64'(if_id_valid), 64'h0);
    check("flush_insn", 64'(if_id_instruction), 64'h13);
    tick();
    check("tgt_insn", 64'(if_id_instruction), 64'h00C28293);
    check("tgt_ifpc", if_id_pc, 64'h40);

    redirect(64'h46);
    check("mis_pc", pc, 64'h44);
    check("mis_set", 64'(misaligned), 64'h1);
    tick();
    redirect(64'h40);
    check("mis_sticky", 64'(misaligned), 64'h1);

    redirect(64'h1000);
    check("oor_pc", pc, 64'h1000);
    tick();
    check("oor_insn", 64'(if_id_instruction), 64'h13);
    check("oor_valid", 64'(if_id_valid), 64'h1);
    check("oor_ifpc", if_id_pc, 64'h1000);

    redirect(64'h50);
    imem_we = 1'b1; imem_waddr = 64'h50; imem_wdata = 32'h00200593;
    tick();
    imem_we = 1'b0;
    check("wr_old_word", 64'(if_id_instruction), 64'h00100513);
    redirect(64'h50);
    tick();
    check("wr_new_word", 64'(if_id_instruction), 64'h00200593);

    imem_we = 1'b1; imem_waddr = 64'h400; imem_wdata = 32'hDEADBEEF;
    tick();
    imem_waddr = 64'hF; imem_wdata = 32'h00300213;
    tick();
    imem_we = 1'b0;
    redirect(64'h0);
    tick();
    check("wr_drop", 64'(if_id_instruction), 64'h00500093);
    tick(); tick(); tick();
    check("wr_lsb_ignored", 64'(if_id_instruction), 64'h00300213);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_mis", 64'(misaligned), 64'h0);
    check("rst2_pc", pc, 64'h0);
    tick();
    check("imem_kept", 64'(if_id_instruction), 64'h00500093);
    tick();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
